// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller:
//            FSM state encoding and EX-stage forwarding select codes.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

  // Forwarding selects for the EX-stage ALU operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit
// Purpose  : Combinational forwarding select for one EX-stage source operand.
//            The younger producer (MEM) wins over the older one (WB); x0 never
//            forwards.
// Ports    : rs_EX        in  5  source register of the EX instruction
//            rd_MEM       in  5  MEM-stage destination
//            RegWrite_MEM in  1  MEM-stage write enable
//            rd_WB        in  5  WB-stage destination
//            RegWrite_WB  in  1  WB-stage write enable
//            fwd_sel      out 2  FWD_RF / FWD_MEM / FWD_WB
// Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_EX,
  input  logic [4:0] rd_MEM,
  input  logic       RegWrite_MEM,
  input  logic [4:0] rd_WB,
  input  logic       RegWrite_WB,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (RegWrite_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs_EX)) begin
      fwd_sel = FWD_MEM;
    end else if (RegWrite_WB && (rd_WB != 5'd0) && (rd_WB == rs_EX)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard/sequencing controller for a 5-stage pipeline. Drives the
//            PC and pipeline-register enables and flushes, detects load-use
//            hazards, EX redirects and data-memory waits, selects EX-stage
//            forwarding and keeps stall/flush statistics.
// Params   : LOAD_BUBBLES 1..3  bubbles per load-use hazard
//            MEM_TIMEOUT        wait cycles before forced release, 0 = never
// Ports    : clk, rst (async, active-low)
//            rs1_ID/rs2_ID, rs1_used/rs2_used       ID-stage sources
//            rd_EX, RegWrite_EX, DatatoReg_EX       EX-stage destination/load
//            rs1_EX/rs2_EX                          EX-stage sources
//            rd_MEM/RegWrite_MEM, rd_WB/RegWrite_WB later-stage writers
//            branch_taken_EX                        EX redirect
//            mem_req_MEM, mem_ack                   data-memory handshake
//            PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  stage enables
//            IF_ID_flush, ID_EX_flush               nop insertion
//            ForwardA/ForwardB                      operand forwarding selects
//            mem_err                                sticky wait timeout flag
//            stall_cnt/flush_cnt                    wrapping statistics
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic [4:0]  rd_EX,
  input  logic        RegWrite_EX,
  input  logic        DatatoReg_EX,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic [4:0]  rd_MEM,
  input  logic        RegWrite_MEM,
  input  logic [4:0]  rd_WB,
  input  logic        RegWrite_WB,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ack,
  output logic        PC_EN,
  output logic        IF_ID_EN,
  output logic        ID_EX_EN,
  output logic        EX_MEM_EN,
  output logic        MEM_WB_EN,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Wait counter holds 0..MEM_TIMEOUT-1 completed wait cycles.
  localparam int             TO_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  // Remaining bubbles after the one issued in the detection cycle.
  localparam logic [1:0]     BUB_INIT = 2'(LOAD_BUBBLES - 1);

  hz_state_t       state, next_state;
  logic [1:0]      bubble_cnt, bubble_nxt;
  logic [TO_W-1:0] wait_cnt, wait_nxt;
  logic            mem_wait, load_use, timeout_hit, err_set, redirect;

  assign mem_wait    = mem_req_MEM & ~mem_ack;
  assign load_use    = DatatoReg_EX & RegWrite_EX & (rd_EX != 5'd0) &
                       ((rs1_used & (rs1_ID == rd_EX)) | (rs2_used & (rs2_ID == rd_EX)));
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_comb begin
    PC_EN       = 1'b1;
    IF_ID_EN    = 1'b1;
    ID_EX_EN    = 1'b1;
    EX_MEM_EN   = 1'b1;
    MEM_WB_EN   = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    next_state  = state;
    bubble_nxt  = bubble_cnt;
    wait_nxt    = '0;
    err_set     = 1'b0;
    redirect    = 1'b0;

    if (mem_wait) begin
      if (timeout_hit) begin
        // Forced release: pipeline runs, any pending bubbles are dropped.
        err_set    = 1'b1;
        next_state = ST_RUN;
        bubble_nxt = '0;
      end else begin
        PC_EN      = 1'b0;
        IF_ID_EN   = 1'b0;
        ID_EX_EN   = 1'b0;
        EX_MEM_EN  = 1'b0;
        MEM_WB_EN  = 1'b0;
        next_state = ST_MEM_WAIT;
        if (MEM_TIMEOUT != 0) begin
          wait_nxt = wait_cnt + TO_W'(1);
        end
      end
    end else begin
      case (state)
        ST_MEM_WAIT: begin
          // Ack cycle: everything advances; a frozen load-use stall resumes.
          next_state = (bubble_cnt != 2'd0) ? ST_LU_STALL : ST_RUN;
        end
        ST_LU_STALL: begin
          if (branch_taken_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            redirect    = 1'b1;
            bubble_nxt  = '0;
            next_state  = ST_RUN;
          end else begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_flush = 1'b1;
            bubble_nxt  = bubble_cnt - 2'd1;
            if (bubble_cnt == 2'd1) begin
              next_state = ST_RUN;
            end
          end
        end
        default: begin
          if (branch_taken_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            redirect    = 1'b1;
          end else if (load_use) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_flush = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bubble_nxt = BUB_INIT;
              next_state = ST_LU_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      bubble_cnt <= '0;
      wait_cnt   <= '0;
      mem_err    <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= next_state;
      bubble_cnt <= bubble_nxt;
      wait_cnt   <= wait_nxt;
      if (err_set) begin
        mem_err <= 1'b1;
      end
      if (!PC_EN) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (redirect) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  fwd_unit u_fwd_a (
    .rs_EX        (rs1_EX),
    .rd_MEM       (rd_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .rd_WB        (rd_WB),
    .RegWrite_WB  (RegWrite_WB),
    .fwd_sel      (ForwardA)
  );

  fwd_unit u_fwd_b (
    .rs_EX        (rs2_EX),
    .rd_MEM       (rd_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .rd_WB        (rd_WB),
    .RegWrite_WB  (RegWrite_WB),
    .fwd_sel      (ForwardB)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. Two instances share
//            stimulus: A (LOAD_BUBBLES=1, MEM_TIMEOUT=8) and
//            B (LOAD_BUBBLES=3, MEM_TIMEOUT=0). Each is compared against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  // {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_flush, ID_EX_flush}
  localparam logic [6:0] ALL_GO   = 7'b1111100;
  localparam logic [6:0] BUBBLE   = 7'b0011101;
  localparam logic [6:0] REDIRECT = 7'b1111111;
  localparam logic [6:0] FROZEN   = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_EX, rs1_EX, rs2_EX, rd_MEM, rd_WB;
  logic       rs1_used, rs2_used, RegWrite_EX, DatatoReg_EX, RegWrite_MEM, RegWrite_WB;
  logic       branch_taken_EX, mem_req_MEM, mem_ack;

  logic        pc_a, ifid_a, idex_a, exmem_a, memwb_a, ifidf_a, idexf_a, err_a;
  logic        pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifidf_b, idexf_b, err_b;
  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic [31:0] stall_a, flush_a, stall_b, flush_b;
  logic [6:0]  en_a, en_b;

  assign en_a = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, ifidf_a, idexf_a};
  assign en_b = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifidf_b, idexf_b};

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .DatatoReg_EX(DatatoReg_EX),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM),
    .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB), .branch_taken_EX(branch_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .PC_EN(pc_a), .IF_ID_EN(ifid_a), .ID_EX_EN(idex_a), .EX_MEM_EN(exmem_a),
    .MEM_WB_EN(memwb_a), .IF_ID_flush(ifidf_a), .ID_EX_flush(idexf_a),
    .ForwardA(fa_a), .ForwardB(fb_a), .mem_err(err_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .DatatoReg_EX(DatatoReg_EX),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM),
    .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB), .branch_taken_EX(branch_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .PC_EN(pc_b), .IF_ID_EN(ifid_b), .ID_EX_EN(idex_b), .EX_MEM_EN(exmem_b),
    .MEM_WB_EN(memwb_b), .IF_ID_flush(ifidf_b), .ID_EX_flush(idexf_b),
    .ForwardA(fa_b), .ForwardB(fb_b), .mem_err(err_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  // Reference model: bubbles still owed, length of the current wait, whether
  // the previous cycle was a stalled wait, and the statistics.
  typedef struct {
    int          bub;
    int          waited;
    bit          waiting;
    bit          err;
    int unsigned stalls;
    int unsigned flushes;
  } model_t;

  model_t ma, mb;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWrite_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b10;
    if (RegWrite_WB && rd_WB != 0 && rd_WB == rs)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] step_model(inout model_t m, input int lb, input int mt);
    logic [6:0] en;
    logic       lu;
    lu = DatatoReg_EX && RegWrite_EX && rd_EX != 0 &&
         ((rs1_used && rs1_ID == rd_EX) || (rs2_used && rs2_ID == rd_EX));
    en = ALL_GO;
    if (mem_req_MEM && !mem_ack) begin
      m.waited++;
      if (mt != 0 && m.waited == mt) begin
        m.err = 1; m.waiting = 0; m.waited = 0; m.bub = 0;
      end else begin
        en = FROZEN; m.waiting = 1; m.stalls++;
      end
    end else if (m.waiting) begin
      m.waiting = 0; m.waited = 0;
    end else begin
      m.waited = 0;
      if (branch_taken_EX) begin
        en = REDIRECT; m.flushes++; m.bub = 0;
      end else if (m.bub > 0) begin
        en = BUBBLE; m.bub--; m.stalls++;
      end else if (lu) begin
        en = BUBBLE; m.bub = lb - 1; m.stalls++;
      end
    end
    return en;
  endfunction

  task automatic idle();
    rs1_ID = 0; rs2_ID = 0; rs1_used = 0; rs2_used = 0;
    rd_EX = 0; RegWrite_EX = 0; DatatoReg_EX = 0;
    rs1_EX = 0; rs2_EX = 0; rd_MEM = 0; RegWrite_MEM = 0; rd_WB = 0; RegWrite_WB = 0;
    branch_taken_EX = 0; mem_req_MEM = 0; mem_ack = 0;
  endtask

  task automatic load_use_x5();
    DatatoReg_EX = 1; RegWrite_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used = 1;
  endtask

  // Checks one clock cycle: combinational outputs at the negedge, then the edge.
  task automatic do_cycle();
    model_t     oa, ob;
    logic [6:0] ea, eb;
    @(negedge clk);
    oa = ma; ob = mb;
    ea = step_model(ma, 1, 8);
    eb = step_model(mb, 3, 0);
    chk("en_a", {25'd0, en_a}, {25'd0, ea});
    chk("en_b", {25'd0, en_b}, {25'd0, eb});
    chk("fwd_a", {28'd0, fa_a, fb_a}, {28'd0, fwd_ref(rs1_EX), fwd_ref(rs2_EX)});
    chk("fwd_b", {28'd0, fa_b, fb_b}, {28'd0, fwd_ref(rs1_EX), fwd_ref(rs2_EX)});
    chk("stall_a", stall_a, oa.stalls);
    chk("stall_b", stall_b, ob.stalls);
    chk("flush_a", flush_a, oa.flushes);
    chk("flush_b", flush_b, ob.flushes);
    chk("err_a", {31'd0, err_a}, {31'd0, oa.err});
    chk("err_b", {31'd0, err_b}, {31'd0, ob.err});
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between clock edges and checks its effect before any edge.
  task automatic do_reset();
    idle();
    rst_n = 0;
    #2;
    ma = '{default: 0};
    mb = '{default: 0};
    chk("rst_en_a", {25'd0, en_a}, {25'd0, ALL_GO});
    chk("rst_en_b", {25'd0, en_b}, {25'd0, ALL_GO});
    chk("rst_stall_a", stall_a, 0);
    chk("rst_stall_b", stall_b, 0);
    chk("rst_flush_a", flush_a, 0);
    chk("rst_err_a", {31'd0, err_a}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Load-use: one bubble on A, three on B.
    load_use_x5();
    do_cycle();
    idle();
    do_cycle();
    chk("lu_stall_a", stall_a, 1);
    do_cycle();
    do_cycle();
    chk("lu_stall_b", stall_b, 3);

    // Load to x0 never stalls.
    do_reset();
    DatatoReg_EX = 1; RegWrite_EX = 1; rd_EX = 0; rs1_ID = 0; rs1_used = 1;
    do_cycle();
    chk("x0_stall_a", stall_a, 0);

    // Redirect beats a same-cycle load-use.
    do_reset();
    load_use_x5();
    branch_taken_EX = 1;
    do_cycle();
    chk("redir_flush_a", flush_a, 1);
    chk("redir_stall_a", stall_a, 0);
    idle();
    do_cycle();

    // Redirect aborts an ongoing load-use stall on B.
    do_reset();
    load_use_x5();
    do_cycle();
    idle();
    branch_taken_EX = 1;
    do_cycle();
    idle();
    do_cycle();
    chk("abort_stall_b", stall_b, 1);

    // Memory wait: 4 frozen cycles, ack releases.
    do_reset();
    mem_req_MEM = 1;
    repeat (4) do_cycle();
    mem_ack = 1;
    do_cycle();
    idle();
    do_cycle();
    chk("mw_stall_a", stall_a, 4);

    // Timeout on A after 8 wait cycles; B never times out.
    do_reset();
    mem_req_MEM = 1;
    repeat (8) do_cycle();
    chk("to_err_a", {31'd0, err_a}, 1);
    chk("to_err_b", {31'd0, err_b}, 0);
    idle();
    repeat (3) do_cycle();
    chk("to_hold_a", {31'd0, err_a}, 1);
    do_reset();

    // Memory wait during a load-use stall freezes B's bubbles.
    load_use_x5();
    do_cycle();
    idle();
    mem_req_MEM = 1;
    repeat (2) do_cycle();
    mem_ack = 1;
    do_cycle();
    idle();
    repeat (3) do_cycle();
    chk("freeze_stall_b", stall_b, 5);

    // Reset in the middle of a stall on B.
    load_use_x5();
    do_cycle();
    idle();
    do_reset();

    // Forwarding priority and x0 suppression.
    rs1_EX = 7; rd_MEM = 7; RegWrite_MEM = 1; rd_WB = 7; RegWrite_WB = 1;
    do_cycle();
    chk("fwd_mem", {30'd0, fa_a}, 2'b10);
    RegWrite_MEM = 0;
    do_cycle();
    chk("fwd_wb", {30'd0, fa_a}, 2'b01);
    rs1_EX = 0; rd_MEM = 0; rd_WB = 0; RegWrite_MEM = 1;
    do_cycle();
    chk("fwd_x0", {30'd0, fa_a}, 2'b00);

    // Randomized traffic on a small register set to make hazards frequent.
    for (int i = 0; i < 2000; i++) begin
      rs1_ID          = 5'($urandom_range(0, 3));
      rs2_ID          = 5'($urandom_range(0, 3));
      rs1_used        = 1'($urandom);
      rs2_used        = 1'($urandom);
      rd_EX           = 5'($urandom_range(0, 3));
      RegWrite_EX     = 1'($urandom);
      DatatoReg_EX    = 1'($urandom);
      rs1_EX          = 5'($urandom_range(0, 3));
      rs2_EX          = 5'($urandom_range(0, 3));
      rd_MEM          = 5'($urandom_range(0, 3));
      RegWrite_MEM    = 1'($urandom);
      rd_WB           = 5'($urandom_range(0, 3));
      RegWrite_WB     = 1'($urandom);
      branch_taken_EX = ($urandom_range(0, 9) == 0);
      mem_req_MEM     = ($urandom_range(0, 4) == 0);
      mem_ack         = ($urandom_range(0, 2) == 0);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
